rle_decoder_block: RTL

//  Run-length decoder: inverse of the DCT->threshold->RLE compression path.

---
 rtl/rle_decoder_block.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rle_decoder_block.sv
// ---------------------------------------------------------------------------
// rle_decoder_block
//
// Run-length decoder sitting between the compressed-stream source and the
// inverse transform. Each accepted (value, count) pair is expanded into
// `count` copies of `value`, written one sample per cycle into an 8-slot
// coefficient block. A completed block is held on out_blk until the
// downstream stage takes it. Runs longer than the free slots carry over
// into the next block.
//
// Optional feature macro: RLE_DEC_STATS_EN
//   When defined, adds output blk_cnt[15:0], which counts completed output
//   handshakes (including flushed partial blocks) and wraps at 0xFFFF.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (name inherited from the codebase)
//   in_valid   input pair valid
//   in_ready   decoder can accept a pair (IDLE, no flush, not in reset)
//   in_value   signed run value, DATA_W bits
//   in_count   unsigned run length, CNT_W bits
//   flush      close the partial block, padding with zeros (IDLE only)
//   out_valid  out_blk holds a complete block
//   out_ready  downstream accepts the block
//   out_blk    slot k at bits [k*DATA_W +: DATA_W], slot 0 is the first sample
//   blk_cnt    (RLE_DEC_STATS_EN only) completed output handshakes
//   zero_err   one-cycle pulse after a pair with in_count == 0 was consumed
// ---------------------------------------------------------------------------
module rle_decoder_block #(
    parameter int DATA_W = 13,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_value,
    input  logic [CNT_W-1:0]         in_count,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*DATA_W-1:0]      out_blk,
`ifdef RLE_DEC_STATS_EN
    output logic [15:0]              blk_cnt,
`endif
    output logic                     zero_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        FULL
    } state_t;

    state_t                        state_q, state_d;
    logic [2:0]                    idx_q, idx_d;
    logic [CNT_W-1:0]              rem_q, rem_d;
    logic [DATA_W-1:0]             val_q, val_d;
    logic [7:0][DATA_W-1:0]        blk_q, blk_d;
    logic                          zero_err_q, zero_err_d;
`ifdef RLE_DEC_STATS_EN
    logic [15:0]                   blk_cnt_q, blk_cnt_d;
`endif

    // Next-state and output decode. Slots beyond the write index are always
    // zero because a handshake clears the whole block, so a flush only has to
    // move to FULL. The write index wraps to 0 on the eighth write, but the
    // handshake in FULL reloads it anyway, so the wrap is harmless.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        val_d      = val_q;
        blk_d      = blk_q;
        zero_err_d = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
`ifdef RLE_DEC_STATS_EN
        blk_cnt_d  = blk_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = ~flush;
                if (flush) begin
                    if (idx_q != 3'd0) begin
                        state_d = FULL;
                    end
                end else if (in_valid) begin
                    if (in_count == '0) begin
                        zero_err_d = 1'b1;
                    end else begin
                        val_d   = in_value;
                        rem_d   = in_count;
                        state_d = EXPAND;
                    end
                end
            end

            EXPAND: begin
                blk_d[idx_q] = val_q;
                idx_d        = idx_q + 3'd1;
                rem_d        = rem_q - CNT_W'(1);
                if (idx_q == 3'd7) begin
                    state_d = FULL;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end

            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_d   = 3'd0;
                    blk_d   = '0;
                    state_d = (rem_q != '0) ? EXPAND : IDLE;
`ifdef RLE_DEC_STATS_EN
                    blk_cnt_d = blk_cnt_q + 16'd1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // No pair may be taken while reset is being applied.
        if (rst_n) begin
            in_ready = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-high reset; a reset
    // mid-run drops both the pending run and the partial block.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            rem_q      <= '0;
            val_q      <= '0;
            blk_q      <= '0;
            zero_err_q <= 1'b0;
`ifdef RLE_DEC_STATS_EN
            blk_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            val_q      <= val_d;
            blk_q      <= blk_d;
            zero_err_q <= zero_err_d;
`ifdef RLE_DEC_STATS_EN
            blk_cnt_q  <= blk_cnt_d;
`endif
        end
    end

    assign out_blk  = blk_q;
    assign zero_err = zero_err_q;
`ifdef RLE_DEC_STATS_EN
    assign blk_cnt  = blk_cnt_q;
`endif

endmodule
